// File: rtl/edge_div_pkg.sv
// Shared definitions for the edge counting divider.
// Edge-select encodings, default depth and the edge-qualify helper.
package edge_div_pkg;

    localparam logic [1:0] EDGE_FALL = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    localparam int SYNC_STAGES_DEF = 2;

    // s: current level, h: level one cycle earlier
    function automatic logic edge_fn(
        input logic [1:0] sel,
        input logic       s,
        input logic       h
    );
        logic r;
        r = 1'b0;
        unique case (1'b1)
            sel == EDGE_FALL: r = ~s & h;
            sel == EDGE_RISE: r = s & ~h;
            sel == EDGE_BOTH: r = s ^ h;
            sel == EDGE_NONE: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Synchroniser, optional stability filter, priming and edge strobe.
// Ports: clk, rst_n, en_in (async), edge_sel[1:0] -> edge_stb.
// EDGE_COUNT_DIVIDER_GLITCH_FILT_EN adds a FILT_LEN-cycle filter.
module edge_sync_det
    import edge_div_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_in,
    input  logic [1:0] edge_sel,
    output logic       edge_stb
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], en_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_COUNT_DIVIDER_GLITCH_FILT_EN
    localparam int FC_W    = $clog2(FILT_LEN + 1);
    // Window also covers the filter so a level held through
    // reset is not mistaken for an edge.
    localparam int PRIME_N = SYNC_STAGES + 1 + FILT_LEN;

    logic [FC_W-1:0] fcnt_q;
    logic            filt_q;

    // fcnt_q counts consecutive cycles s has differed from filt_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            filt_q <= 1'b0;
        end else if (s == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
            fcnt_q <= '0;
            filt_q <= s;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    localparam int PRIME_N = SYNC_STAGES + 1;

    assign lvl = s;
`endif

    localparam int PC_W = $clog2(PRIME_N + 1);

    logic [PC_W-1:0] prime_q;
    logic            primed;

    assign primed = (prime_q == PC_W'(PRIME_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_q <= '0;
        end else if (!primed) begin
            prime_q <= prime_q + 1'b1;
        end
    end

    // History keeps tracking during priming so the first
    // armed cycle compares against a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= lvl;
        end
    end

    assign edge_stb = primed & edge_fn(edge_sel, lvl, hist_q);

endmodule

// File: rtl/edge_count_divider.sv
// Counts selected en_in edges modulo div_n; pulse and toggle on wrap.
// Ports: clk, rst_n, en_in, edge_sel, div_n, clr -> div_pulse,
// div_level, cnt_out. Option: EDGE_COUNT_DIVIDER_GLITCH_FILT_EN.
module edge_count_divider
    import edge_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic [1:0]       edge_sel,
    input  logic [CNT_W-1:0] div_n,
    input  logic             clr,
    output logic             div_pulse,
    output logic             div_level,
    output logic [CNT_W-1:0] cnt_out
);

    logic edge_stb;
    logic at_top;

    edge_sync_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_in    (en_in),
        .edge_sel (edge_sel),
        .edge_stb (edge_stb)
    );

    // >= so a lowered div_n wraps on the next edge
    assign at_top = (cnt_out >= div_n - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out   <= '0;
            div_pulse <= 1'b0;
            div_level <= 1'b0;
        end else if (clr) begin
            cnt_out   <= '0;
            div_pulse <= 1'b0;
        end else if (div_n == '0) begin
            cnt_out   <= '0;
            div_pulse <= 1'b0;
        end else if (edge_stb && at_top) begin
            cnt_out   <= '0;
            div_pulse <= 1'b1;
            div_level <= ~div_level;
        end else if (edge_stb) begin
            cnt_out   <= cnt_out + 1'b1;
            div_pulse <= 1'b0;
        end else begin
            div_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_count_divider.sv
// Self-checking bench for edge_count_divider (default build).
// Table vectors plus directed sequences; scoreboard queue.
module tb_edge_count_divider;

    logic       clk;
    logic       rst_n;
    logic       en_in;
    logic [1:0] edge_sel;
    logic [7:0] div_n;
    logic       clr;
    logic       div_pulse;
    logic       div_level;
    logic [7:0] cnt_out;

    edge_count_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_in     (en_in),
        .edge_sel  (edge_sel),
        .div_n     (div_n),
        .clr       (clr),
        .div_pulse (div_pulse),
        .div_level (div_level),
        .cnt_out   (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int pulse;
        int level;
    } exp_t;

    typedef struct {
        logic en;
        int   cnt;
        int   pulse;
        int   level;
    } vec_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pulse_seen = 0;

    always @(negedge clk) begin
        if (div_pulse === 1'b1) pulse_seen++;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic v);
        rst_n = 1'b0;
        en_in = v;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Drive en_in at a negedge, result expected three cycles later
    task automatic edge_chk(input logic  v,
                            input int    ecnt,
                            input int    epulse,
                            input int    elevel,
                            input string nm);
        exp_t e;
        e.cnt   = ecnt;
        e.pulse = epulse;
        e.level = elevel;
        en_in = v;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_pre"}, 32'(div_pulse), 0);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({nm, "_sb"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_cnt"}, 32'(cnt_out), 32'(e.cnt));
            chk({nm, "_pls"}, 32'(div_pulse), 32'(e.pulse));
            chk({nm, "_lvl"}, 32'(div_level), 32'(e.level));
        end
        @(negedge clk);
        chk({nm, "_w"}, 32'(div_pulse), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   p0;
        tbl[0] = '{1'b1, 1, 0, 0};
        tbl[1] = '{1'b0, 2, 0, 0};
        tbl[2] = '{1'b1, 0, 1, 1};
        tbl[3] = '{1'b0, 1, 0, 1};
        tbl[4] = '{1'b1, 2, 0, 1};
        tbl[5] = '{1'b0, 0, 1, 0};

        // T0: reset and priming with en_in already high
        rst_n    = 1'b1;
        en_in    = 1'b1;
        clr      = 1'b0;
        edge_sel = 2'b01;
        div_n    = 8'd4;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt", 32'(cnt_out), 0);
        chk("rst_pls", 32'(div_pulse), 0);
        chk("rst_lvl", 32'(div_level), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("prime_cnt%0d", i),
                32'(cnt_out), 0);
            chk($sformatf("prime_pls%0d", i),
                32'(div_pulse), 0);
        end
        edge_chk(1'b0, 0, 0, 0, "t0_fall");
        edge_chk(1'b1, 1, 0, 0, "t0_rise");

        // T1: falling edges, divide by 10
        do_reset(1'b1);
        edge_sel = 2'b00;
        div_n    = 8'd10;
        p0 = pulse_seen;
        for (int i = 1; i <= 20; i++) begin
            edge_chk(1'b0, i % 10, (i % 10 == 0) ? 1 : 0,
                     (i >= 10 && i < 20) ? 1 : 0,
                     $sformatf("t1_f%0d", i));
            edge_chk(1'b1, i % 10, 0,
                     (i >= 10 && i < 20) ? 1 : 0,
                     $sformatf("t1_r%0d", i));
        end
        chk("t1_pulses", 32'(pulse_seen - p0), 2);

        // T2: both edges, divide by 3, table driven
        do_reset(1'b0);
        edge_sel = 2'b10;
        div_n    = 8'd3;
        foreach (tbl[i]) begin
            edge_chk(tbl[i].en, tbl[i].cnt, tbl[i].pulse,
                     tbl[i].level, $sformatf("t2_v%0d", i));
        end

        // T3: div_n lowered mid-count, then clr vs edge
        do_reset(1'b0);
        edge_sel = 2'b01;
        div_n    = 8'd10;
        for (int i = 1; i <= 7; i++) begin
            edge_chk(1'b1, i, 0, 0, $sformatf("t3_r%0d", i));
            edge_chk(1'b0, i, 0, 0, $sformatf("t3_f%0d", i));
        end
        div_n = 8'd5;
        edge_chk(1'b1, 0, 1, 1, "t3_lower");
        edge_chk(1'b0, 0, 0, 1, "t3_lf");
        edge_chk(1'b1, 1, 0, 1, "t3_a");
        edge_chk(1'b0, 1, 0, 1, "t3_af");
        edge_chk(1'b1, 2, 0, 1, "t3_b");
        edge_chk(1'b0, 2, 0, 1, "t3_bf");
        en_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t3_clr_cnt", 32'(cnt_out), 0);
        chk("t3_clr_pls", 32'(div_pulse), 0);
        chk("t3_clr_lvl", 32'(div_level), 1);
        @(negedge clk);
        chk("t3_clr_late", 32'(cnt_out), 0);
        edge_chk(1'b0, 0, 0, 1, "t3_cf");
        edge_chk(1'b1, 1, 0, 1, "t3_cr");

        // T4: divider disabled, then edges masked
        do_reset(1'b0);
        edge_sel = 2'b10;
        div_n    = 8'd0;
        p0 = pulse_seen;
        for (int i = 0; i < 50; i++) begin
            en_in = ~en_in;
            repeat (2) @(negedge clk);
            chk($sformatf("t4_d%0d", i), 32'(cnt_out), 0);
        end
        div_n    = 8'd4;
        edge_sel = 2'b11;
        for (int i = 0; i < 50; i++) begin
            en_in = ~en_in;
            repeat (2) @(negedge clk);
            chk($sformatf("t4_n%0d", i), 32'(cnt_out), 0);
        end
        repeat (4) @(negedge clk);
        chk("t4_pulses", 32'(pulse_seen - p0), 0);

        // T5: async reset mid-count
        do_reset(1'b0);
        edge_sel = 2'b01;
        div_n    = 8'd10;
        for (int i = 1; i <= 16; i++) begin
            edge_chk(1'b1, i % 10, (i == 10) ? 1 : 0,
                     (i >= 10) ? 1 : 0,
                     $sformatf("t5_r%0d", i));
            edge_chk(1'b0, i % 10, 0, (i >= 10) ? 1 : 0,
                     $sformatf("t5_f%0d", i));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_cnt", 32'(cnt_out), 0);
        chk("t5_async_pls", 32'(div_pulse), 0);
        chk("t5_async_lvl", 32'(div_level), 0);
        @(negedge clk);
        do_reset(1'b0);
        edge_chk(1'b1, 1, 0, 0, "t5_after");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/edge_count_divider.md
Name: edge_count_divider

Overview:
- Parametrised successor to the UART enable-edge divider.
- Synchronises an asynchronous strobe, detects the selected edge type, and counts those edges modulo a runtime divide value. Each wrap emits a one-cycle pulse and toggles a square-wave level.
- Sits between the UART bit-timing enables and the frame/byte logic, e.g. one pulse per 10 bit-enable falling edges.

Parameters:
- CNT_W, 8, width of the edge counter and of div_n.
- SYNC_STAGES, 2, number of input synchroniser flops (legal range 2..4).
- FILT_LEN, 3, glitch-filter stability length in clk cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_in  in  1  asynchronous strobe to be counted.
- edge_sel  in  2  edge select: 00 falling, 01 rising, 10 both, 11 none (counting frozen).
- div_n  in  CNT_W  edges per wrap; 0 disables the divider.
- clr  in  1  synchronous counter clear.
- div_pulse  out  1  one-cycle pulse on each wrap.
- div_level  out  1  toggles on each wrap.
- cnt_out  out  CNT_W  current edge count.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All synchroniser flops, the edge-history flop, cnt_out, div_pulse and div_level go to 0.
  - The prime counter is cleared.
- Priming after reset release:
  - Edge detection is suppressed for SYNC_STAGES+1 cycles so that a level already present on en_in is not counted.
  - The history flop still tracks the synchronised input during this window.
- Edge detect:
  - edge_stb is combinational, formed from the last synchroniser stage s and the history flop h.
  - falling = ~s & h; rising = s & ~h; both = s ^ h.
  - edge_sel = 11 forces edge_stb to 0.
- Latency: an en_in transition set up before clk edge k produces div_pulse high in the cycle after edge k+SYNC_STAGES. This is SYNC_STAGES+1 cycles (3 at default).
- Counter, registered, evaluated in priority order:
  1. clr = 1: cnt_out <= 0, div_pulse <= 0, div_level unchanged. clr wins over a simultaneous edge, and that edge is lost.
  2. div_n = 0: cnt_out <= 0, div_pulse <= 0, no edges counted.
  3. edge_stb = 1 and cnt_out >= div_n-1: cnt_out <= 0, div_pulse <= 1, div_level <= ~div_level. The >= comparison handles div_n being lowered mid-count; the wrap happens on the next edge.
  4. edge_stb = 1 otherwise: cnt_out <= cnt_out+1, div_pulse <= 0.
  5. No edge: div_pulse <= 0, counter holds.
- div_n = 1: div_pulse fires on every selected edge.
- Maximum ratio is 2^CNT_W-1. Arithmetic is unsigned, and the counter never exceeds div_n-1 except transiently after div_n is lowered.
- div_pulse is never high for two consecutive cycles unless two qualifying edges reach the synchroniser on consecutive cycles. Back-to-back edges are counted individually.
- edge_sel and div_n are sampled every cycle and are expected quasi-static. A change takes effect on the next edge_stb evaluation.
- Reset asserted mid-count aborts immediately and returns everything to reset values; priming restarts on release.

Optional Feature:
- Macro: EDGE_COUNT_DIVIDER_GLITCH_FILT_EN.
- When defined:
  - A stability filter sits after the synchroniser.
  - The filtered level updates only after the synchronised input has held a new value for FILT_LEN consecutive cycles.
  - Latency grows by FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are ignored.
- When undefined: the last synchroniser stage feeds edge detection directly, with the latency above.

Decomposition:
- Shared package edge_div_pkg holds:
  - edge_sel encodings: EDGE_FALL = 2'b00, EDGE_RISE = 2'b01, EDGE_BOTH = 2'b10, EDGE_NONE = 2'b11.
  - Default SYNC_STAGES.
- One sub-module, edge_sync_det: synchroniser, optional filter, priming, history flop and edge_stb generation.
- The top level holds the counter and outputs.

Test Plan:
- Reset release with en_in held at 1, edge_sel = 01, div_n = 4 -> no count and no pulse during priming; cnt_out stays 0.
- edge_sel = 00, div_n = 10, apply 20 falling edges spaced 8 cycles apart -> div_pulse fires exactly twice; each pulse is 3 cycles after the 10th/20th edge enters; div_level goes 0 -> 1 -> 0.
- edge_sel = 10, div_n = 3, toggle en_in every 4 cycles 6 times -> 2 pulses; cnt_out sequence 1, 2, 0, 1, 2, 0.
- At cnt_out = 7 with div_n = 10, change div_n to 5, then apply one edge -> wrap to 0 with one div_pulse. Separately, assert clr on the same cycle as edge_stb -> cnt_out = 0 and no pulse.
- div_n = 0, or edge_sel = 11, with 50 edges applied -> cnt_out = 0 and div_pulse never asserts. Assert rst_n low mid-count at cnt_out = 6 -> all outputs 0 asynchronously.
- With EDGE_COUNT_DIVIDER_GLITCH_FILT_EN and FILT_LEN = 3: a 2-cycle low glitch is not counted; a 5-cycle low pulse is counted once, with pulse latency 6 cycles.
